// File: rtl/demodulate.sv
// FM discriminator: conjugate product, quantized arctangent via restoring divider, gain; 37 cycles rd_en->wr_en.
// Pops both input FIFOs together only in IDLE; holds the result in WRITE while the output FIFO is full.
module demodulate #(
  parameter int DATA_SIZE = 32,
  parameter int BITS      = 10,
  parameter int GAIN      = 758,
  parameter int QUAD1     = 804,
  parameter int QUAD3     = 2412
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] real_in_dout,
  input  logic                 real_in_empty,
  output logic                 real_in_rd_en,
  input  logic [DATA_SIZE-1:0] imag_in_dout,
  input  logic                 imag_in_empty,
  output logic                 imag_in_rd_en,
  output logic [DATA_SIZE-1:0] demod_out_din,
  output logic                 demod_out_wr_en,
  input  logic                 demod_out_full
);

  localparam int W2 = 2 * DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_SIZE - 1);
  localparam logic [W2-1:0] RND = (W2'(1) << BITS) - W2'(1);
  localparam int MSB = DATA_SIZE - 1;

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_SETUP, S_DIV, S_ANGLE, S_GAIN, S_WRITE} state_t;

  state_t r_state, w_next;
  logic [DATA_SIZE-1:0] r_cr, r_ci, r_pr, r_pi, r_r, r_i, r_base, r_den;
  logic [DATA_SIZE-1:0] r_rem, r_quo, r_angle, r_dout;
  logic                 r_qneg;
  logic [CW-1:0]        r_cnt;

  logic signed [W2-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir, w_p_ang, w_p_gain;
  logic [DATA_SIZE-1:0] w_r, w_i, w_abs_y, w_diff, w_den, w_base, w_num, w_num_abs, w_q, w_angle;
  logic [DATA_SIZE:0]   w_shift, w_sub;
  logic                 w_rd, w_wr;

  function automatic logic signed [W2-1:0] sx(input logic [DATA_SIZE-1:0] v);
    return {{DATA_SIZE{v[MSB]}}, v};
  endfunction

  // Dequantize with truncation toward zero (bias negatives before the arithmetic shift).
  function automatic logic signed [W2-1:0] deq(input logic signed [W2-1:0] x);
    logic signed [W2-1:0] t;
    t = x[W2-1] ? (x + RND) : x;
    return t >>> BITS;
  endfunction

  assign w_p_rr = sx(r_pr) * sx(r_cr);
  assign w_p_ii = sx(r_pi) * sx(r_ci);
  assign w_p_ri = sx(r_pr) * sx(r_ci);
  assign w_p_ir = sx(r_pi) * sx(r_cr);
  assign w_r    = DATA_SIZE'(deq(w_p_rr) - deq(-w_p_ii));
  assign w_i    = DATA_SIZE'(deq(w_p_ri) + deq(-w_p_ir));

  always_comb begin
    w_abs_y = (r_i[MSB] ? -r_i : r_i) + DATA_SIZE'(1);
    w_diff  = r_r - w_abs_y;
    w_den   = r_r + w_abs_y;
    w_base  = DATA_SIZE'(QUAD1);
    if (r_r[MSB]) begin
      w_diff = r_r + w_abs_y;
      w_den  = w_abs_y - r_r;
      w_base = DATA_SIZE'(QUAD3);
    end
    w_num     = w_diff << BITS;
    w_num_abs = w_num[MSB] ? -w_num : w_num;
  end

  assign w_shift  = {r_rem, r_quo[MSB]};
  assign w_sub    = w_shift - {1'b0, r_den};
  assign w_q      = r_qneg ? -r_quo : r_quo;
  assign w_p_ang  = sx(DATA_SIZE'(QUAD1)) * sx(w_q);
  assign w_p_gain = sx(DATA_SIZE'(GAIN)) * sx(r_angle);

  always_comb begin
    w_angle = DATA_SIZE'(sx(r_base) - deq(w_p_ang));
    if (r_i[MSB]) w_angle = -w_angle;
  end

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    case (r_state)
      S_IDLE: if (reset && !real_in_empty && !imag_in_empty) begin
        w_rd   = 1'b1;
        w_next = S_MULT;
      end
      S_MULT:  w_next = S_SETUP;
      S_SETUP: w_next = S_DIV;
      S_DIV:   if (r_cnt == CNT_LAST) w_next = S_ANGLE;
      S_ANGLE: w_next = S_GAIN;
      S_GAIN:  w_next = S_WRITE;
      S_WRITE: if (reset && !demod_out_full) begin
        w_wr   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign real_in_rd_en   = w_rd;
  assign imag_in_rd_en   = w_rd;
  assign demod_out_wr_en = w_wr;
  assign demod_out_din   = r_dout;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cr <= '0; r_ci <= '0; r_pr <= '0; r_pi <= '0;
      r_r <= '0; r_i <= '0; r_base <= '0; r_den <= '0;
      r_rem <= '0; r_quo <= '0; r_qneg <= 1'b0; r_cnt <= '0;
      r_angle <= '0; r_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_rd) begin
          r_cr <= real_in_dout;
          r_ci <= imag_in_dout;
        end
        S_MULT: begin
          r_r  <= w_r;
          r_i  <= w_i;
          r_pr <= r_cr;
          r_pi <= r_ci;
        end
        S_SETUP: begin
          r_base <= w_base;
          r_den  <= w_den;
          r_rem  <= '0;
          r_quo  <= w_num_abs;
          r_qneg <= w_num[MSB];
          r_cnt  <= '0;
        end
        // Dividend shifts out of r_quo while quotient bits shift in behind it.
        S_DIV: begin
          if (!w_sub[DATA_SIZE]) begin
            r_rem <= w_sub[DATA_SIZE-1:0];
            r_quo <= {r_quo[DATA_SIZE-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[DATA_SIZE-1:0];
            r_quo <= {r_quo[DATA_SIZE-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CW'(1);
        end
        S_ANGLE: r_angle <= w_angle;
        S_GAIN:  r_dout  <= DATA_SIZE'(deq(w_p_gain));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_demodulate.sv
// Directed and randomized check of demodulate against an arithmetic reference of the discriminator.
module tb_demodulate;

  logic        clock;
  logic        reset;
  logic [31:0] real_in_dout, imag_in_dout, demod_out_din;
  logic        real_in_empty, imag_in_empty, real_in_rd_en, imag_in_rd_en;
  logic        demod_out_wr_en, demod_out_full;

  int checks   = 0;
  int failures = 0;
  int m_pr     = 0;
  int m_pi     = 0;

  demodulate dut (
    .clock          (clock),
    .reset          (reset),
    .real_in_dout   (real_in_dout),
    .real_in_empty  (real_in_empty),
    .real_in_rd_en  (real_in_rd_en),
    .imag_in_dout   (imag_in_dout),
    .imag_in_empty  (imag_in_empty),
    .imag_in_rd_en  (imag_in_rd_en),
    .demod_out_din  (demod_out_din),
    .demod_out_wr_en(demod_out_wr_en),
    .demod_out_full (demod_out_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Reference discriminator: plain integer arithmetic, division truncates toward zero.
  function automatic int model(input int cr, input int ci);
    int r, i, abs_y, num, den, base, q, angle;
    r = int'((longint'(m_pr) * cr) / 1024 - (-(longint'(m_pi) * ci)) / 1024);
    i = int'((longint'(m_pr) * ci) / 1024 + (-(longint'(m_pi) * cr)) / 1024);
    m_pr = cr;
    m_pi = ci;
    abs_y = (i < 0 ? -i : i) + 1;
    if (r >= 0) begin
      num = (r - abs_y) * 1024; den = r + abs_y; base = 804;
    end else begin
      num = (r + abs_y) * 1024; den = abs_y - r; base = 2412;
    end
    q = num / den;
    angle = int'(base - (longint'(804) * q) / 1024);
    if (i < 0) angle = -angle;
    return int'((longint'(758) * angle) / 1024);
  endfunction

  task automatic do_sample(input int cr, input int ci, input int hold, input int exp);
    int n, lat;
    real_in_dout = cr; imag_in_dout = ci;
    real_in_empty = 1'b0; imag_in_empty = 1'b0;
    #1;
    n = 0;
    while (!real_in_rd_en && n < 60) begin step(); #1; n++; end
    chk("rd_wait", n, 0);
    chk("rd_real", real_in_rd_en, 1);
    chk("rd_imag", imag_in_rd_en, 1);
    demod_out_full = (hold > 0);
    step();
    real_in_empty = 1'b1; imag_in_empty = 1'b1;
    lat = 1;
    if (hold == 0) begin
      while (!demod_out_wr_en && lat < 60) begin step(); lat++; end
      chk("wr_latency", lat, 37);
    end else begin
      while (lat < 37) begin step(); lat++; end
      real_in_empty = 1'b0; imag_in_empty = 1'b0;
      for (int k = 0; k < hold; k++) begin
        #1;
        chk("bp_wr", demod_out_wr_en, 0);
        chk("bp_rd", real_in_rd_en, 0);
        chk("bp_din", longint'($signed(demod_out_din)), exp);
        step();
      end
      demod_out_full = 1'b0;
      #1;
      chk("bp_release_wr", demod_out_wr_en, 1);
    end
    chk("dout", longint'($signed(demod_out_din)), exp);
    step();
    chk("wr_single", demod_out_wr_en, 0);
  endtask

  initial begin
    int cr, ci, e;
    reset = 1'b0;
    real_in_dout = 32'd1024; imag_in_dout = 32'd0;
    real_in_empty = 1'b0; imag_in_empty = 1'b0;
    demod_out_full = 1'b0;

    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_rd_real", real_in_rd_en, 0);
      chk("rst_rd_imag", imag_in_rd_en, 0);
      chk("rst_wr", demod_out_wr_en, 0);
      chk("rst_din", longint'($signed(demod_out_din)), 0);
    end
    reset = 1'b1;

    // Directed sequence with hand-computed outputs.
    void'(model(1024, 0));  do_sample(1024, 0, 0, 1190);
    void'(model(1024, 0));  do_sample(1024, 0, 0, 1);
    void'(model(0, 1024));  do_sample(0, 1024, 0, 1190);
    e = model(1024, 0);     do_sample(1024, 0, 0, e);
    void'(model(0, -1024)); do_sample(0, -1024, 0, -1190);

    // Backpressure on a random sample.
    cr = int'($urandom_range(0, 32767)) - 16384;
    ci = int'($urandom_range(0, 32767)) - 16384;
    e = model(cr, ci);
    do_sample(cr, ci, 10, e);

    // Only the real FIFO has data: no pop may happen.
    real_in_empty = 1'b0; imag_in_empty = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("uneq_rd_real", real_in_rd_en, 0);
      chk("uneq_rd_imag", imag_in_rd_en, 0);
      step();
    end
    cr = int'($urandom_range(0, 32767)) - 16384;
    ci = int'($urandom_range(0, 32767)) - 16384;
    e = model(cr, ci);
    do_sample(cr, ci, 0, e);

    for (int k = 0; k < 20; k++) begin
      cr = int'($urandom_range(0, 32767)) - 16384;
      ci = int'($urandom_range(0, 32767)) - 16384;
      e = model(cr, ci);
      do_sample(cr, ci, 0, e);
    end

    // Reset in the middle of the divide: sample is dropped, history cleared.
    real_in_dout = 32'd5000; imag_in_dout = -32'sd3000;
    real_in_empty = 1'b0; imag_in_empty = 1'b0;
    #1;
    chk("abort_rd", real_in_rd_en, 1);
    step();
    real_in_empty = 1'b1; imag_in_empty = 1'b1;
    for (int k = 0; k < 19; k++) step();
    reset = 1'b0;
    step();
    chk("abort_wr", demod_out_wr_en, 0);
    chk("abort_din", longint'($signed(demod_out_din)), 0);
    reset = 1'b1;
    for (int k = 0; k < 45; k++) begin
      chk("abort_no_wr", demod_out_wr_en, 0);
      step();
    end
    m_pr = 0; m_pi = 0;
    void'(model(1024, 0));
    do_sample(1024, 0, 0, 1190);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demodulate.md
# demodulate

FM discriminator stage of the fm_radio datapath; consumes the decimated I/Q stream from the real/imag FIFOs fed by fir_cmplx. Computes the conjugate product of each complex sample with the previous one, then the quantized arctangent of that product (iterative divider), then applies the demodulation gain. Produces one 32-bit audio-rate sample per input pair into the downstream FIFO consumed by the audio filters.

## Interface
- DATA_SIZE, 32: sample width, signed two's complement.
- BITS, 10: fixed-point fraction bits. QUANT(x) = x·2^BITS; DEQ(x) = x/2^BITS, truncating toward zero.
- GAIN, 758: demodulation gain, QUANT(0.7407).
- QUAD1, 804: QUANT(π/4). QUAD3, 2412: QUANT(3π/4).
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low.
- real_in_dout  in  DATA_SIZE  I sample, valid while real_in_empty=0.
- real_in_empty  in  1  real FIFO empty.
- real_in_rd_en  out  1  pop real FIFO.
- imag_in_dout  in  DATA_SIZE  Q sample, valid while imag_in_empty=0.
- imag_in_empty  in  1  imag FIFO empty.
- imag_in_rd_en  out  1  pop imag FIFO.
- demod_out_din  out  DATA_SIZE  demodulated sample.
- demod_out_wr_en  out  1  push to output FIFO.
- demod_out_full  in  1  output FIFO full.

## Operation
- States: IDLE, MULT, SETUP, DIV, ANGLE, GAIN, WRITE.
- IDLE: when real_in_empty=0 and imag_in_empty=0, latch cr/ci from dout, assert both rd_en for exactly that cycle, go MULT. Both rd_en always asserted together; never popped if either FIFO is empty.
- MULT: 64-bit signed products, results truncated to 32 bits: r = DEQ(pr·cr) − DEQ(−pi·ci); i = DEQ(pr·ci) + DEQ(−pi·cr). Then pr←cr, pi←ci. Go SETUP.
- SETUP: abs_y = |i| + 1. If r ≥ 0: num = QUANT(r − abs_y), den = r + abs_y, base = QUAD1; else num = QUANT(r + abs_y), den = abs_y − r, base = QUAD3. den > 0 always. Load divider with |num|, den, quotient sign = sign(num). Go DIV.
- DIV: restoring divider, one quotient bit per cycle, 32 cycles; quotient q truncated toward zero, sign applied on exit. Go ANGLE.
- ANGLE: angle = base − DEQ(QUAD1·q); if i < 0, angle = −angle. Go GAIN.
- GAIN: demod_out_din ← DEQ(GAIN·angle). Go WRITE.
- WRITE: demod_out_wr_en = !demod_out_full; on the write cycle return to IDLE. While full, hold state and demod_out_din.
- pr/pi persist across samples; reset to 0.

## Timing
- Reset (reset=0 at edge): state IDLE; pr, pi, divider regs, demod_out_din = 0; all rd_en/wr_en = 0. Reset at any state, including mid-DIV or WRITE with full, aborts the sample; no partial write.
- rd_en and wr_en are combinational from state and empty/full flags; asserted for one cycle per transfer.
- Latency: rd_en in cycle T; MULT T+1; SETUP T+2; DIV T+3..T+34; ANGLE T+35; GAIN T+36; demod_out_wr_en earliest T+37.
- Throughput: one sample per 38 cycles. Next rd_en earliest the cycle after the write.
- Input read only in IDLE; inputs become non-empty mid-computation are ignored until return to IDLE.
- Arithmetic: all signed; every DEQ truncates toward zero (not arithmetic shift), matching the C golden model.

## Test plan
- Reset: hold reset=0 3 cycles with FIFOs non-empty -> no rd_en/wr_en, demod_out_din=0; release -> rd_en at first cycle in IDLE with both FIFOs non-empty.
- First sample (1024,0) after reset, prev=0 -> r=i=0, q=−1024, angle 1608, output 1190, wr_en exactly 37 cycles after rd_en.
- Then (1024,0) -> r=1024, i=0, q=1022, angle 2, output 1; then (0,1024) -> i=1024, output 1190; then (0,−1024) with prev reset to (1024,0) -> angle −1608, output −1190 (truncation toward zero).
- Backpressure: demod_out_full=1 for 10 cycles in WRITE -> wr_en low, din stable, no rd_en; release -> single wr_en, then IDLE.
- Unequal FIFOs: real non-empty, imag empty 20 cycles -> neither rd_en asserts; imag becomes non-empty -> both assert same cycle.
- Reset at T+20 (mid-DIV) -> no write; pr/pi back to 0; next sample (1024,0) yields 1190.
